// File: rtl/univ_shift_reg.sv
// Universal register: parallel load, clear and multi-cycle shift/rotate
// commands with serial in/out, complemented output and a done pulse.
// Multi-position shifts are sequenced by a two-state FSM, one bit per
// enabled cycle.
module univ_shift_reg #(
  parameter int unsigned           WIDTH   = 8,
  parameter int unsigned           AMT_W   = 4,
  parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             so,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_CLR  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_ASR  = 3'd5;
  localparam logic [2:0] OP_ROL  = 3'd6;
  localparam logic [2:0] OP_ROR  = 3'd7;

  localparam logic [AMT_W-1:0] AMT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] AMT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   cnt_q,   cnt_d;
  logic [2:0]         op_q,    op_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic               so_q,    so_d;
  logic               done_q,  done_d;

  // One-bit shift/rotate result for the latched op (used only in BUSY).
  function automatic logic [WIDTH:0] shift_one(input logic [2:0]       op,
                                               input logic [WIDTH-1:0] val,
                                               input logic             sin);
    // Returns {serial_out, new_value}.
    logic [WIDTH:0] res;
    case (op)
      OP_SHL:  res = {val[WIDTH-1], val[WIDTH-2:0], sin};
      OP_SHR:  res = {val[0], sin, val[WIDTH-1:1]};
      OP_ASR:  res = {val[0], val[WIDTH-1], val[WIDTH-1:1]};
      OP_ROL:  res = {val[WIDTH-1], val[WIDTH-2:0], val[WIDTH-1]};
      OP_ROR:  res = {val[0], val[0], val[WIDTH-1:1]};
      default: res = {1'b0, val};
    endcase
    return res;
  endfunction

  // Next-state logic: command decode in IDLE, one shift per cycle in BUSY;
  // everything holds when clk_en is low.
  always_comb begin
    logic [WIDTH:0] sh_s;
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    so_d    = so_q;
    done_d  = done_q;
    sh_s    = shift_one(op_q, data_q, si);
    if (clk_en) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_NOP:  done_d = 1'b1;
              OP_LOAD: begin
                data_d = d;
                done_d = 1'b1;
              end
              OP_CLR: begin
                data_d = {WIDTH{1'b0}};
                done_d = 1'b1;
              end
              default: begin
                // Shift/rotate ops; a zero amount completes like a NOP.
                if (cmd_amt == AMT_ZERO) begin
                  done_d = 1'b1;
                end else begin
                  op_d    = cmd_op;
                  cnt_d   = cmd_amt;
                  state_d = ST_BUSY;
                end
              end
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          data_d = sh_s[WIDTH-1:0];
          so_d   = sh_s[WIDTH];
          cnt_d  = cnt_q - AMT_ONE;
          if (cnt_q == AMT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset taking priority over clk_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= AMT_ZERO;
      op_q    <= OP_NOP;
      data_q  <= RST_VAL;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  assign q         = data_q;
  assign q_n       = ~data_q;
  assign so        = so_q;
  assign done      = done_q;
  assign busy      = (state_q == ST_BUSY);
  assign cmd_ready = (state_q == ST_IDLE) | rst;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed, table-driven bench for univ_shift_reg (WIDTH=8, AMT_W=4).
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst, clk_en, cmd_valid, si;
  logic       cmd_ready, so, busy, done;
  logic [2:0] cmd_op;
  logic [3:0] cmd_amt;
  logic [7:0] d, q, q_n;

  int tests_run = 0;
  int tests_failed = 0;

  univ_shift_reg #(.WIDTH(8), .AMT_W(4), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_amt(cmd_amt), .d(d),
    .si(si), .q(q), .q_n(q_n), .so(so), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, en, vld;
    logic [2:0] op;
    logic [3:0] amt;
    logic [7:0] d;
    logic       si;
    logic [7:0] eq;
    logic       eso, ebusy, edone, erdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic r, logic en, logic vld,
                              logic [2:0] op, logic [3:0] amt, logic [7:0] dd,
                              logic s, logic [7:0] eq, logic eso, logic eb,
                              logic ed, logic er);
    vec_t v;
    v.name = name; v.rst = r; v.en = en; v.vld = vld; v.op = op;
    v.amt = amt; v.d = dd; v.si = s; v.eq = eq; v.eso = eso;
    v.ebusy = eb; v.edone = ed; v.erdy = er;
    return v;
  endfunction

  task automatic drive(logic r, logic en, logic vld, logic [2:0] op,
                       logic [3:0] amt, logic [7:0] dd, logic s);
    rst = r; clk_en = en; cmd_valid = vld; cmd_op = op;
    cmd_amt = amt; d = dd; si = s;
  endtask

  task automatic chk(string name, logic [7:0] eq, logic eso, logic eb,
                     logic ed, logic er);
    logic [7:0] eqn;
    eqn = ~eq;
    tests_run++;
    if (q !== eq || q_n !== eqn || so !== eso || busy !== eb ||
        done !== ed || cmd_ready !== er) begin
      tests_failed++;
      $display("FAIL %s: got q=%h q_n=%h so=%b busy=%b done=%b rdy=%b, want q=%h q_n=%h so=%b busy=%b done=%b rdy=%b",
               name, q, q_n, so, busy, done, cmd_ready,
               eq, eqn, eso, eb, ed, er);
    end
  endtask

  task automatic step_chk(string name, logic [7:0] eq, logic eso, logic eb,
                          logic ed, logic er);
    @(posedge clk);
    #1;
    chk(name, eq, eso, eb, ed, er);
  endtask

  initial begin
    //             name         rst en vld op    amt    d      si   q      so   busy done rdy
    vecs.push_back(mk("reset",    1, 0, 0, 3'd0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk("ld_a5",    0, 1, 1, 3'd1, 4'd0, 8'hA5, 0, 8'hA5, 0, 0, 1, 1));
    vecs.push_back(mk("shl_acc",  0, 1, 1, 3'd3, 4'd3, 8'h00, 1, 8'hA5, 0, 1, 0, 0));
    vecs.push_back(mk("shl_1",    0, 1, 0, 3'd0, 4'd0, 8'h00, 1, 8'h4B, 1, 1, 0, 0));
    vecs.push_back(mk("shl_2",    0, 1, 0, 3'd0, 4'd0, 8'h00, 1, 8'h97, 0, 1, 0, 0));
    vecs.push_back(mk("shl_3",    0, 1, 0, 3'd0, 4'd0, 8'h00, 1, 8'h2F, 1, 0, 1, 1));
    vecs.push_back(mk("shl_idle", 0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'h2F, 1, 0, 0, 1));
    vecs.push_back(mk("ld_90",    0, 1, 1, 3'd1, 4'd0, 8'h90, 0, 8'h90, 1, 0, 1, 1));
    vecs.push_back(mk("asr_acc",  0, 1, 1, 3'd5, 4'd2, 8'h00, 0, 8'h90, 1, 1, 0, 0));
    vecs.push_back(mk("asr_1",    0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'hC8, 0, 1, 0, 0));
    vecs.push_back(mk("asr_2",    0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'hE4, 0, 0, 1, 1));
    vecs.push_back(mk("ld_81",    0, 1, 1, 3'd1, 4'd0, 8'h81, 0, 8'h81, 0, 0, 1, 1));
    vecs.push_back(mk("ror_acc",  0, 1, 1, 3'd7, 4'd8, 8'h00, 0, 8'h81, 0, 1, 0, 0));
    vecs.push_back(mk("ror_1",    0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'hC0, 1, 1, 0, 0));
    vecs.push_back(mk("ror_2",    0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'h60, 0, 1, 0, 0));
    vecs.push_back(mk("ror_3",    0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'h30, 0, 1, 0, 0));
    vecs.push_back(mk("ror_4",    0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'h18, 0, 1, 0, 0));
    vecs.push_back(mk("ror_5",    0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'h0C, 0, 1, 0, 0));
    vecs.push_back(mk("ror_6",    0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'h06, 0, 1, 0, 0));
    vecs.push_back(mk("ror_7",    0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'h03, 0, 1, 0, 0));
    vecs.push_back(mk("ror_8",    0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'h81, 1, 0, 1, 1));
    vecs.push_back(mk("nop_1",    0, 1, 1, 3'd0, 4'd0, 8'h00, 0, 8'h81, 1, 0, 1, 1));
    vecs.push_back(mk("nop_2",    0, 1, 1, 3'd0, 4'd0, 8'h00, 0, 8'h81, 1, 0, 1, 1));
    vecs.push_back(mk("nop_end",  0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'h81, 1, 0, 0, 1));
    vecs.push_back(mk("clr",      0, 1, 1, 3'd2, 4'd0, 8'hFF, 0, 8'h00, 1, 0, 1, 1));
    vecs.push_back(mk("ld_3c",    0, 1, 1, 3'd1, 4'd0, 8'h3C, 0, 8'h3C, 1, 0, 1, 1));
    vecs.push_back(mk("rol_acc",  0, 1, 1, 3'd6, 4'd5, 8'h00, 0, 8'h3C, 1, 1, 0, 0));
    vecs.push_back(mk("rol_1",    0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'h78, 0, 1, 0, 0));
    vecs.push_back(mk("rol_2",    0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'hF0, 0, 1, 0, 0));
    vecs.push_back(mk("rol_rst",  1, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk("no_done",  0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk("shl0_rst", 0, 1, 1, 3'd3, 4'd0, 8'h00, 1, 8'h00, 0, 0, 1, 1));
    vecs.push_back(mk("ld_5a",    0, 1, 1, 3'd1, 4'd0, 8'h5A, 0, 8'h5A, 0, 0, 1, 1));
    vecs.push_back(mk("shl0",     0, 1, 1, 3'd3, 4'd0, 8'h00, 1, 8'h5A, 0, 0, 1, 1));
    vecs.push_back(mk("shl0_end", 0, 1, 0, 3'd0, 4'd0, 8'h00, 0, 8'h5A, 0, 0, 0, 1));
    vecs.push_back(mk("ld_11",    0, 1, 1, 3'd1, 4'd0, 8'h11, 0, 8'h11, 0, 0, 1, 1));
    vecs.push_back(mk("en0_hold", 0, 0, 1, 3'd1, 4'd0, 8'h22, 0, 8'h11, 0, 0, 1, 1));
    vecs.push_back(mk("en1_clr",  0, 1, 0, 3'd1, 4'd0, 8'h22, 0, 8'h11, 0, 0, 0, 1));

    drive(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].op,
            vecs[i].amt, vecs[i].d, vecs[i].si);
      step_chk(vecs[i].name, vecs[i].eq, vecs[i].eso, vecs[i].ebusy,
               vecs[i].edone, vecs[i].erdy);
    end

    // SHR amt=4 with a two-cycle clk_en stall and a LOAD offered while busy.
    drive(1'b0, 1'b1, 1'b1, 3'd1, 4'd0, 8'hB4, 1'b0);
    step_chk("shr_ld_b4", 8'hB4, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 3'd4, 4'd4, 8'h00, 1'b0);
    step_chk("shr_acc", 8'hB4, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 3'd1, 4'd0, 8'hFF, 1'b1);
    step_chk("shr_1", 8'hDA, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 3'd1, 4'd0, 8'hFF, 1'b0);
    step_chk("shr_frz1", 8'hDA, 1'b0, 1'b1, 1'b0, 1'b0);
    step_chk("shr_frz2", 8'hDA, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 3'd1, 4'd0, 8'hFF, 1'b0);
    step_chk("shr_2", 8'h6D, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 3'd1, 4'd0, 8'hFF, 1'b1);
    step_chk("shr_3", 8'hB6, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 3'd1, 4'd0, 8'hFF, 1'b0);
    step_chk("shr_4_done", 8'h5B, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 3'd1, 4'd0, 8'hFF, 1'b0);
    step_chk("shr_no_queue", 8'h5B, 1'b0, 1'b0, 1'b0, 1'b1);

    // SHL with amt > WIDTH refills entirely from si.
    drive(1'b0, 1'b1, 1'b1, 3'd3, 4'd10, 8'h00, 1'b1);
    step_chk("shl10_acc", 8'h5B, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 8'h00, 1'b1);
    for (int k = 1; k < 10; k++) begin
      @(posedge clk);
    end
    #1;
    chk("shl10_last", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    step_chk("shl10_done", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
